// File: rtl/bus_err_inj_pkg.sv
// Shared types for the response-path error injector: queued entry layout and
// the helper that sizes index/pointer fields.
package bus_err_inj_pkg;

    // Widest error code an entry can carry; narrower codes are zero-extended.
    localparam int unsigned MaxErrBits = 8;

    typedef struct packed {
        logic                  inj;
        logic [MaxErrBits-1:0] code;
    } inj_entry_t;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO with flush; the head is readable combinationally.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module fifo_v3
    import bus_err_inj_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 testmode_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 push_i,
    output logic [DataWidth-1:0] data_o,
    input  logic                 pop_i,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int unsigned PtrW = idx_width(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [DataWidth-1:0] mem_reg [Depth];
    logic [PtrW-1:0]      wr_ptr_reg;
    logic [PtrW-1:0]      rd_ptr_reg;
    logic [CntW-1:0]      cnt_reg;
    logic                 do_push;
    logic                 do_pop;
    logic                 unused_testmode;

    assign unused_testmode = testmode_i;

    assign full_o  = (cnt_reg == CntW'(Depth));
    assign empty_o = (cnt_reg == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= (wr_ptr_reg == PtrW'(Depth - 1)) ? '0 : wr_ptr_reg + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PtrW'(Depth - 1)) ? '0 : rd_ptr_reg + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_reg <= cnt_reg + CntW'(1);
                2'b01:   cnt_reg <= cnt_reg - CntW'(1);
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

endmodule

// File: rtl/onehot_to_bin.sv
// One-hot to binary index encoder; an all-zero input encodes as index 0.
module onehot_to_bin
    import bus_err_inj_pkg::*;
#(
    parameter int unsigned OneHotWidth = 4,
    parameter int unsigned BinWidth    = idx_width(OneHotWidth)
) (
    input  logic [OneHotWidth-1:0] onehot_i,
    output logic [BinWidth-1:0]    bin_o
);

    always_comb begin
        bin_o = '0;
        for (int i = 0; i < OneHotWidth; i++) begin
            if (onehot_i[i]) begin
                bin_o = bin_o | BinWidth'(i);
            end
        end
    end

endmodule

// File: rtl/bus_err_injector.sv
// Response-path error injector: marks requests hitting an address window and
// overrides the error code of every beat of each marked response burst.
module bus_err_injector
    import bus_err_inj_pkg::*;
#(
    parameter int unsigned AddrWidth      = 48,
    parameter int unsigned ErrBits        = 3,
    parameter int unsigned NumOutstanding = 4,
    parameter int unsigned NumChannels    = 1,
    parameter int unsigned CntWidth       = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   testmode_i,
    input  logic                   cfg_en_i,
    input  logic [AddrWidth-1:0]   cfg_addr_base_i,
    input  logic [AddrWidth-1:0]   cfg_addr_mask_i,
    input  logic [ErrBits-1:0]     cfg_err_code_i,
    input  logic [CntWidth-1:0]    cfg_count_i,
    input  logic                   cfg_arm_i,
    input  logic [NumChannels-1:0] req_hs_valid_i,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic [NumChannels-1:0] rsp_hs_valid_i,
    input  logic [NumChannels-1:0] rsp_burst_last_i,
    input  logic [ErrBits-1:0]     rsp_err_i,
    output logic [ErrBits-1:0]     rsp_err_o,
    output logic [CntWidth-1:0]    inj_remaining_o,
    output logic [CntWidth-1:0]    inj_count_o,
    output logic                   inj_overflow_o
);

    localparam int unsigned IdxW   = idx_width(NumChannels);
    localparam int unsigned SelNum = 2 ** IdxW;

    logic [CntWidth-1:0]    remaining_reg;
    logic [CntWidth-1:0]    count_reg;
    logic                   overflow_reg;
    logic [NumChannels-1:0] dead_reg;

    logic [NumChannels-1:0] full, empty, push, pop, die, pop_marked, unused_head;
    inj_entry_t             head [NumChannels];
    inj_entry_t             new_entry;
    logic                   addr_hit;
    logic                   decrement;

    logic [IdxW-1:0]        rsp_idx;
    logic [SelNum-1:0]      sel_hit;
    logic [ErrBits-1:0]     sel_code [SelNum];

    assign addr_hit       = ((req_addr_i ^ cfg_addr_base_i) & cfg_addr_mask_i) == '0;
    assign new_entry.inj  = cfg_en_i & (remaining_reg != '0) & addr_hit;
    assign new_entry.code = MaxErrBits'(cfg_err_code_i);

    // All-ones budget means unlimited: never count down.
    assign decrement = (|push) & new_entry.inj & (remaining_reg != '1);

    generate
        for (genvar gi = 0; gi < NumChannels; gi++) begin : g_chan
            assign pop[gi]  = rsp_hs_valid_i[gi] & rsp_burst_last_i[gi] & ~empty[gi] & ~dead_reg[gi];
            assign push[gi] = req_hs_valid_i[gi] & ~dead_reg[gi] & (~full[gi] | pop[gi]);
            assign die[gi]  = req_hs_valid_i[gi] & ~dead_reg[gi] & full[gi] & ~pop[gi];
            assign pop_marked[gi]  = pop[gi] & head[gi].inj;
            assign unused_head[gi] = ^head[gi];

            fifo_v3 #(
                .DataWidth ($bits(inj_entry_t)),
                .Depth     (NumOutstanding)
            ) u_fifo (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .flush_i    (cfg_arm_i),
                .testmode_i (testmode_i),
                .data_i     (new_entry),
                .push_i     (push[gi]),
                .data_o     (head[gi]),
                .pop_i      (pop[gi]),
                .full_o     (full[gi]),
                .empty_o    (empty[gi])
            );
        end

        // Selection table padded to a power of two so the encoded index is always in range.
        for (genvar gi = 0; gi < SelNum; gi++) begin : g_sel
            if (gi < NumChannels) begin : g_real
                assign sel_hit[gi]  = ~empty[gi] & ~dead_reg[gi] & head[gi].inj;
                assign sel_code[gi] = head[gi].code[ErrBits-1:0];
            end else begin : g_pad
                assign sel_hit[gi]  = 1'b0;
                assign sel_code[gi] = '0;
            end
        end
    endgenerate

    onehot_to_bin #(
        .OneHotWidth (NumChannels),
        .BinWidth    (IdxW)
    ) u_rsp_sel (
        .onehot_i (rsp_hs_valid_i),
        .bin_o    (rsp_idx)
    );

    always_comb begin
        rsp_err_o = rsp_err_i;
        if ((|rsp_hs_valid_i) && sel_hit[rsp_idx]) begin
            rsp_err_o = sel_code[rsp_idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            remaining_reg <= '0;
            overflow_reg  <= 1'b0;
            dead_reg      <= '0;
        end else if (cfg_arm_i) begin
            remaining_reg <= cfg_count_i;
            overflow_reg  <= 1'b0;
            dead_reg      <= '0;
        end else begin
            if (decrement) begin
                remaining_reg <= remaining_reg - CntWidth'(1);
            end
            dead_reg <= dead_reg | die;
            if (|die) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_reg <= '0;
        end else if ((|pop_marked) && (count_reg != '1)) begin
            count_reg <= count_reg + CntWidth'(1);
        end
    end

    assign inj_remaining_o = remaining_reg;
    assign inj_count_o     = count_reg;
    assign inj_overflow_o  = overflow_reg;

endmodule

// File: tb/tb_bus_err_injector.sv
// Directed bench for bus_err_injector with two channels and depth-4 FIFOs.
module tb_bus_err_injector;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        testmode_i;
    logic        cfg_en_i;
    logic [47:0] cfg_addr_base_i;
    logic [47:0] cfg_addr_mask_i;
    logic [2:0]  cfg_err_code_i;
    logic [15:0] cfg_count_i;
    logic        cfg_arm_i;
    logic [1:0]  req_hs_valid_i;
    logic [47:0] req_addr_i;
    logic [1:0]  rsp_hs_valid_i;
    logic [1:0]  rsp_burst_last_i;
    logic [2:0]  rsp_err_i;
    logic [2:0]  rsp_err_o;
    logic [15:0] inj_remaining_o;
    logic [15:0] inj_count_o;
    logic        inj_overflow_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    bus_err_injector #(
        .AddrWidth      (48),
        .ErrBits        (3),
        .NumOutstanding (4),
        .NumChannels    (2),
        .CntWidth       (16)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .testmode_i       (testmode_i),
        .cfg_en_i         (cfg_en_i),
        .cfg_addr_base_i  (cfg_addr_base_i),
        .cfg_addr_mask_i  (cfg_addr_mask_i),
        .cfg_err_code_i   (cfg_err_code_i),
        .cfg_count_i      (cfg_count_i),
        .cfg_arm_i        (cfg_arm_i),
        .req_hs_valid_i   (req_hs_valid_i),
        .req_addr_i       (req_addr_i),
        .rsp_hs_valid_i   (rsp_hs_valid_i),
        .rsp_burst_last_i (rsp_burst_last_i),
        .rsp_err_i        (rsp_err_i),
        .rsp_err_o        (rsp_err_o),
        .inj_remaining_o  (inj_remaining_o),
        .inj_count_o      (inj_count_o),
        .inj_overflow_o   (inj_overflow_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Apply one cycle of request/response inputs at the falling edge.
    task automatic drive(input logic [1:0] req, input logic [47:0] addr,
                         input logic [1:0] rsp, input logic [1:0] last, input logic [2:0] err);
        @(negedge clk_i);
        req_hs_valid_i   = req;
        req_addr_i       = addr;
        rsp_hs_valid_i   = rsp;
        rsp_burst_last_i = last;
        rsp_err_i        = err;
        #1;
    endtask

    task automatic idle();
        drive(2'b00, 48'h0, 2'b00, 2'b00, 3'd0);
    endtask

    task automatic req(input int ch, input logic [47:0] addr);
        drive(2'(1 << ch), addr, 2'b00, 2'b00, 3'd0);
    endtask

    task automatic burst(input string tag, input int ch, input int n,
                         input logic [2:0] err, input logic [2:0] exp);
        for (int b = 0; b < n; b++) begin
            drive(2'b00, 48'h0, 2'(1 << ch), (b == n - 1) ? 2'(1 << ch) : 2'b00, err);
            check(tag, 64'(rsp_err_o), 64'(exp));
        end
    endtask

    task automatic arm(input logic [15:0] cnt);
        @(negedge clk_i);
        cfg_count_i = cnt;
        cfg_arm_i   = 1'b1;
        @(negedge clk_i);
        cfg_arm_i   = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
    endtask

    initial begin
        rst_i = 1'b1; testmode_i = 1'b0; cfg_en_i = 1'b0;
        cfg_addr_base_i = '0; cfg_addr_mask_i = '0; cfg_err_code_i = 3'd0;
        cfg_count_i = '0; cfg_arm_i = 1'b0;
        req_hs_valid_i = '0; req_addr_i = '0; rsp_hs_valid_i = '0;
        rsp_burst_last_i = '0; rsp_err_i = '0;
        repeat (2) @(posedge clk_i);
        do_reset();

        // Reset state and passthrough
        check("rst_remaining", 64'(inj_remaining_o), 64'h0);
        check("rst_count", 64'(inj_count_o), 64'h0);
        check("rst_overflow", 64'(inj_overflow_o), 64'h0);
        burst("rst_pass", 0, 1, 3'd5, 3'd5);

        // Window hit
        cfg_en_i = 1'b1; cfg_addr_base_i = 48'h1000; cfg_addr_mask_i = 48'hF000; cfg_err_code_i = 3'd3;
        idle();
        arm(16'd2);
        check("arm_remaining", 64'(inj_remaining_o), 64'd2);
        req(0, 48'h1004);
        req(0, 48'h2000);
        req(0, 48'h1FF0);
        idle();
        check("win_remaining", 64'(inj_remaining_o), 64'd0);
        burst("win_b0", 0, 4, 3'd0, 3'd3);
        burst("win_b1", 0, 4, 3'd0, 3'd0);
        burst("win_b2", 0, 4, 3'd0, 3'd3);
        idle();
        check("win_count", 64'(inj_count_o), 64'd2);

        // Budget exhausted
        arm(16'd1);
        req(0, 48'h1000);
        req(0, 48'h1008);
        idle();
        check("bud_remaining", 64'(inj_remaining_o), 64'd0);
        burst("bud_b0", 0, 2, 3'd2, 3'd3);
        burst("bud_b1", 0, 2, 3'd2, 3'd2);
        idle();
        check("bud_count", 64'(inj_count_o), 64'd3);

        // Unlimited mode
        do_reset();
        check("rst2_count", 64'(inj_count_o), 64'd0);
        arm(16'hFFFF);
        for (int i = 0; i < 10; i++) begin
            req(0, 48'h1000 + 48'(i * 16));
            burst("unl_b", 0, 1, 3'd0, 3'd3);
        end
        idle();
        check("unl_remaining", 64'(inj_remaining_o), 64'hFFFF);
        check("unl_count", 64'(inj_count_o), 64'd10);

        // Overflow and recovery by arm
        for (int i = 0; i < 5; i++) req(0, 48'h1000);
        idle();
        check("ovf_flag", 64'(inj_overflow_o), 64'd1);
        check("ovf_remaining", 64'(inj_remaining_o), 64'hFFFF);
        burst("ovf_dead_b0", 0, 1, 3'd1, 3'd1);
        req(0, 48'h1000);
        burst("ovf_dead_b1", 0, 1, 3'd1, 3'd1);
        idle();
        arm(16'd5);
        check("ovf_cleared", 64'(inj_overflow_o), 64'd0);
        check("ovf_arm_rem", 64'(inj_remaining_o), 64'd5);
        req(0, 48'h1000);
        burst("ovf_resume", 0, 2, 3'd0, 3'd3);
        idle();
        check("ovf_count", 64'(inj_count_o), 64'd11);
        check("ovf_rem_after", 64'(inj_remaining_o), 64'd4);

        // Full FIFO with simultaneous push and pop
        req(0, 48'h1000);
        req(0, 48'h2000);
        req(0, 48'h1000);
        req(0, 48'h2000);
        drive(2'b01, 48'h1000, 2'b01, 2'b01, 3'd0);
        check("full_simul", 64'(rsp_err_o), 64'd3);
        idle();
        check("full_no_ovf", 64'(inj_overflow_o), 64'd0);
        burst("full_d0", 0, 1, 3'd0, 3'd0);
        burst("full_d1", 0, 1, 3'd0, 3'd3);
        burst("full_d2", 0, 1, 3'd0, 3'd0);
        burst("full_d3", 0, 1, 3'd0, 3'd3);
        burst("full_empty", 0, 1, 3'd6, 3'd6);
        // Same-cycle request and response on an empty channel
        drive(2'b01, 48'h1000, 2'b01, 2'b01, 3'd0);
        check("same_cycle", 64'(rsp_err_o), 64'd0);
        burst("same_next", 0, 1, 3'd0, 3'd3);
        idle();
        check("full_remaining", 64'(inj_remaining_o), 64'd0);
        check("full_count", 64'(inj_count_o), 64'd15);
        check("full_ovf_end", 64'(inj_overflow_o), 64'd0);

        // Multi-channel interleave
        arm(16'hFFFF);
        req(0, 48'h1000);
        req(1, 48'h2000);
        req(0, 48'h3000);
        req(1, 48'h1100);
        drive(2'b00, 48'h0, 2'b10, 2'b00, 3'd0);
        check("mc_ch1_beat", 64'(rsp_err_o), 64'd0);
        drive(2'b00, 48'h0, 2'b01, 2'b01, 3'd0);
        check("mc_ch0_hit", 64'(rsp_err_o), 64'd3);
        drive(2'b00, 48'h0, 2'b10, 2'b10, 3'd0);
        check("mc_ch1_last", 64'(rsp_err_o), 64'd0);
        burst("mc_ch1_hit", 1, 1, 3'd0, 3'd3);
        burst("mc_ch0_miss", 0, 1, 3'd0, 3'd0);
        idle();
        check("mc_count", 64'(inj_count_o), 64'd17);

        // Reset mid-burst
        req(0, 48'h1000);
        drive(2'b00, 48'h0, 2'b01, 2'b00, 3'd0);
        check("mid_beat0", 64'(rsp_err_o), 64'd3);
        rst_i = 1'b1;
        drive(2'b00, 48'h0, 2'b01, 2'b00, 3'd4);
        rst_i = 1'b0;
        check("mid_beat1", 64'(rsp_err_o), 64'd4);
        drive(2'b00, 48'h0, 2'b01, 2'b01, 3'd4);
        check("mid_last", 64'(rsp_err_o), 64'd4);
        idle();
        check("mid_count", 64'(inj_count_o), 64'd0);
        check("mid_remaining", 64'(inj_remaining_o), 64'd0);
        check("mid_overflow", 64'(inj_overflow_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
